shifter_operand_pipe: RTL and testbench
=======================================

// Module: shifter_operand_pipe
// PURPOSE
//  Registered, DATA_W-generic successor to the addressing-mode-1 shifter-operand logic.
//  Computes the shifter_operand and shifter_carry for these operand forms:
//   - rotated immediate
//   - immediate-shift
//   - register-shift (costs one extra cycle, as on ARM)
//  Sits between decode/regfile read and the ALU; single-entry, valid/ready on both sides.
// PARAMETERS
//  DATA_W  32  operand width; legal values 16, 32, 64
//  AMT_W   $clog2(DATA_W)  immediate shift-amount field width (derived; do not override)
//  ROT_W   AMT_W-1  rotate field width; the immediate rotates right by 2*rot (derived)
// PORTS
//  clk         in   1        clock
//  rst_n       in   1        asynchronous active-low reset
//  flush       in   1        synchronous kill of any held or in-flight request
//  in_valid    in   1        request valid
//  in_ready    out  1        request accepted when in_valid&in_ready
//  in_mode     in   2        00 IMM_ROT, 01 IMM_SHIFT, 10 REG_SHIFT, 11 PASS (Rm out, carry C)
//  in_stype    in   2        00 LSL, 01 LSR, 10 ASR, 11 ROR
//  in_imm8     in   8        immediate byte (IMM_ROT)
//  in_rot      in   ROT_W    rotate field (IMM_ROT)
//  in_amt      in   AMT_W    immediate shift amount (IMM_SHIFT)
//  in_rs       in   8        Rs[7:0] shift amount (REG_SHIFT)
//  in_rm       in   DATA_W   Rm value
//  in_c        in   1        current CPSR C flag
//  out_valid   out  1        result valid
//  out_ready   in   1        consumer accepts when out_valid&out_ready
//  out_operand out  DATA_W   shifter operand
//  out_carry   out  1        shifter carry-out
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1, out_valid=0, out_operand=0, out_carry=0.
//  FSM:
//   - IDLE --accept, mode!=REG_SHIFT--> DONE
//   - IDLE --accept, mode==REG_SHIFT--> EXEC
//   - EXEC --> DONE (unconditional)
//   - DONE --out_ready--> IDLE, or straight to DONE/EXEC if a new request is accepted that same cycle
//  in_ready = (state==IDLE) | (state==DONE & out_ready); never asserted in EXEC.
//  Latency accept->out_valid: 1 cycle (IMM_ROT/IMM_SHIFT/PASS), 2 cycles (REG_SHIFT). Peak throughput 1/cycle for non-REG modes.
//  All request fields are captured at accept. Output fields are registered and held stable while out_valid & !out_ready.
//  IMM_ROT:
//   - operand = zext(imm8) ROR 2*rot
//   - carry = (rot==0) ? C : operand[DATA_W-1]
//  IMM_SHIFT, amt==0:
//   - LSL -> Rm, carry C
//   - LSR/ASR: amount is DATA_W
//   - ROR -> RRX: {C, Rm[DATA_W-1:1]}, carry Rm[0]
//  REG_SHIFT (n = Rs[7:0]):
//   - n==0 -> Rm, carry C, for every stype
//   - LSL/LSR, n<DATA_W: normal shift
//   - LSL/LSR, n==DATA_W: result 0; carry Rm[0] (LSL) or Rm[DATA_W-1] (LSR)
//   - LSL/LSR, n>DATA_W: result 0, carry 0
//   - ASR, n>=DATA_W: result all sign bits, carry Rm[DATA_W-1]
//   - ROR, n[AMT_W-1:0]==0 (n!=0): result Rm, carry Rm[DATA_W-1]
//   - ROR otherwise: rotate by n mod DATA_W
//  Normal shift carry = last bit shifted out. All arithmetic is DATA_W wide; no other width extension.
//  flush has priority over every transition:
//   - next state IDLE, out_valid=0; held data is dropped
//   - in_ready is forced 0 during a flush cycle
//  Async reset mid-EXEC/DONE: immediately return to reset values; the request is lost.
// STRUCTURE
//  Shared header addr_mode_defs.vh holds the MODE_* and STYPE_* codes and the FSM state encodings.
//  One combinational sub-module, shifter_core (DATA_W param): inputs mode/stype/amount/Rm/C, outputs {carry, operand}.
//  REG_SHIFT amount decode is registered in EXEC and feeds shifter_core.
// TESTING
//  1. IMM_ROT imm8=0xFF rot=4 -> 0xFF000000, carry 1; rot=0, C=1 -> 0x000000FF, carry 1.
//  2. IMM_SHIFT amt=0, Rm=0x80000000:
//     - LSR -> 0, carry 1
//     - ASR -> 0xFFFFFFFF, carry 1
//     - ROR, Rm=1, C=1 -> 0x80000000, carry 1
//  3. REG_SHIFT Rm=1 LSL: Rs=32 -> 0, carry 1; Rs=33 -> 0, carry 0.
//     ROR Rs=32, Rm=0x80000001 -> 0x80000001, carry 1. out_valid 2 cycles after accept.
//  4. out_ready=0 for 5 cycles with result held -> outputs stable, in_ready=0.
//     Then 4 back-to-back IMM_SHIFT requests with out_ready=1 -> 1 result/cycle, in order.
//  5. flush in EXEC and in DONE -> out_valid=0 next cycle, no result emitted.
//     rst_n low mid-EXEC -> all outputs at reset values asynchronously.
//  6. DATA_W=16 build: LSL Rs=16, Rm=0x0001 -> 0, carry 1; IMM_ROT imm8=0x81 rot=1 -> 0x4020, carry 0.

Source files
------------

// File: rtl/shifter_operand_pipe_pkg.sv
// Shared codes, FSM states and shift-amount decode for the shifter-operand pipeline.
package shifter_operand_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_IMM_ROT   = 2'b00,
        MODE_IMM_SHIFT = 2'b01,
        MODE_REG_SHIFT = 2'b10,
        MODE_PASS      = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        STYPE_LSL = 2'b00,
        STYPE_LSR = 2'b01,
        STYPE_ASR = 2'b10,
        STYPE_ROR = 2'b11
    } stype_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // zero: amount is 0; big: amount >= DATA_W; over: amount > DATA_W
    typedef struct packed {
        logic zero;
        logic big;
        logic over;
    } amt_flags_t;

    function automatic amt_flags_t decode_rs(input logic [7:0] rs, input int unsigned data_w);
        amt_flags_t f;
        f.zero = (rs == 8'd0);
        f.big  = (rs >= 8'(data_w));
        f.over = (rs >  8'(data_w));
        return f;
    endfunction

endpackage

// File: rtl/shifter_operand_pipe_if.sv
// Request/result handshake bundle between decode, the shifter pipe and the ALU.
interface shifter_operand_pipe_if #(
    parameter int unsigned DATA_W = 32
) ();
    localparam int unsigned AMT_W = $clog2(DATA_W);
    localparam int unsigned ROT_W = AMT_W - 1;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_mode;
    logic [1:0]        in_stype;
    logic [7:0]        in_imm8;
    logic [ROT_W-1:0]  in_rot;
    logic [AMT_W-1:0]  in_amt;
    logic [7:0]        in_rs;
    logic [DATA_W-1:0] in_rm;
    logic              in_c;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_operand;
    logic              out_carry;

    modport master (
        output in_valid, in_mode, in_stype, in_imm8, in_rot, in_amt, in_rs, in_rm, in_c, out_ready,
        input  in_ready, out_valid, out_operand, out_carry
    );

    modport slave (
        input  in_valid, in_mode, in_stype, in_imm8, in_rot, in_amt, in_rs, in_rm, in_c, out_ready,
        output in_ready, out_valid, out_operand, out_carry
    );
endinterface

// File: rtl/shifter_operand_pipe_shifter_core.sv
// Combinational shifter: operand and carry-out for every addressing form from a pre-decoded amount.
module shifter_core
    import shifter_operand_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  mode_e                        mode,
    input  stype_e                       stype,
    input  logic [$clog2(DATA_W)-1:0]    amt,
    input  amt_flags_t                   flags,
    input  logic [DATA_W-1:0]            rm,
    input  logic                         c,
    output logic [DATA_W-1:0]            operand_c,
    output logic                         carry_c
);
    localparam int unsigned AMT_W = $clog2(DATA_W);

    logic [AMT_W-1:0]  amt_neg;
    logic [AMT_W-1:0]  amt_dec;
    logic [DATA_W-1:0] lsl_v, lsr_v, asr_v, ror_v, sign_v;
    logic              msb;

    // Shift-by-amt results; carries only meaningful when amt != 0
    assign amt_neg = AMT_W'(0) - amt;
    assign amt_dec = amt - AMT_W'(1);
    assign msb     = rm[DATA_W-1];
    assign sign_v  = {DATA_W{msb}};
    assign lsl_v   = rm << amt;
    assign lsr_v   = rm >> amt;
    assign asr_v   = $unsigned($signed(rm) >>> amt);
    assign ror_v   = (rm >> amt) | (rm << amt_neg);

    always_comb begin
        operand_c = rm;
        carry_c   = c;
        case (mode)
            MODE_IMM_ROT: begin
                if (!flags.zero) begin
                    operand_c = ror_v;
                    carry_c   = ror_v[DATA_W-1];
                end
            end
            MODE_IMM_SHIFT: begin
                if (flags.zero) begin
                    case (stype)
                        STYPE_LSL: ;
                        STYPE_LSR: begin operand_c = '0;             carry_c = msb;   end
                        STYPE_ASR: begin operand_c = sign_v;         carry_c = msb;   end
                        STYPE_ROR: begin operand_c = {c, rm[DATA_W-1:1]}; carry_c = rm[0]; end
                    endcase
                end else begin
                    case (stype)
                        STYPE_LSL: begin operand_c = lsl_v; carry_c = rm[amt_neg];      end
                        STYPE_LSR: begin operand_c = lsr_v; carry_c = rm[amt_dec];      end
                        STYPE_ASR: begin operand_c = asr_v; carry_c = rm[amt_dec];      end
                        STYPE_ROR: begin operand_c = ror_v; carry_c = ror_v[DATA_W-1];  end
                    endcase
                end
            end
            MODE_REG_SHIFT: begin
                // n == 0 passes Rm and C through for every shift type
                if (!flags.zero) begin
                    case (stype)
                        STYPE_LSL: begin
                            operand_c = flags.big ? '0 : lsl_v;
                            carry_c   = flags.over ? 1'b0 : (flags.big ? rm[0] : rm[amt_neg]);
                        end
                        STYPE_LSR: begin
                            operand_c = flags.big ? '0 : lsr_v;
                            carry_c   = flags.over ? 1'b0 : (flags.big ? msb : rm[amt_dec]);
                        end
                        STYPE_ASR: begin
                            operand_c = flags.big ? sign_v : asr_v;
                            carry_c   = flags.big ? msb : rm[amt_dec];
                        end
                        STYPE_ROR: begin
                            operand_c = ror_v;
                            carry_c   = (amt == '0) ? msb : ror_v[DATA_W-1];
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/shifter_operand_pipe.sv
// Single-entry registered shifter-operand stage between regfile read and the ALU.
module shifter_operand_pipe
    import shifter_operand_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    shifter_operand_pipe_if.slave   bus
);
    localparam int unsigned AMT_W = $clog2(DATA_W);

    state_e            state, state_n;
    mode_e             in_mode;
    logic              ready, accept, capture, load_out, valid_n;
    logic              valid_q, carry_q;
    logic [DATA_W-1:0] operand_q;

    logic [DATA_W-1:0] src_rm;
    logic [AMT_W-1:0]  src_amt;
    amt_flags_t        src_flags;

    stype_e            h_stype;
    logic [AMT_W-1:0]  h_amt;
    amt_flags_t        h_flags;
    logic [DATA_W-1:0] h_rm;
    logic              h_c;

    mode_e             core_mode;
    stype_e            core_stype;
    logic [AMT_W-1:0]  core_amt;
    amt_flags_t        core_flags;
    logic [DATA_W-1:0] core_rm, core_op;
    logic              core_c, core_cy;

    assign in_mode = mode_e'(bus.in_mode);

    // Normalise the incoming request into {value, amount, amount flags}
    always_comb begin
        src_rm    = bus.in_rm;
        src_amt   = bus.in_amt;
        src_flags = '0;
        case (in_mode)
            MODE_IMM_ROT: begin
                src_rm         = DATA_W'(bus.in_imm8);
                src_amt        = {bus.in_rot, 1'b0};
                src_flags.zero = (bus.in_rot == '0);
            end
            MODE_IMM_SHIFT: src_flags.zero = (bus.in_amt == '0);
            MODE_REG_SHIFT: begin
                src_amt   = bus.in_rs[AMT_W-1:0];
                src_flags = decode_rs(bus.in_rs, DATA_W);
            end
            default: ;
        endcase
    end

    // EXEC evaluates the held register-shift request; otherwise the live request
    always_comb begin
        if (state == ST_EXEC) begin
            core_mode  = MODE_REG_SHIFT;
            core_stype = h_stype;
            core_amt   = h_amt;
            core_flags = h_flags;
            core_rm    = h_rm;
            core_c     = h_c;
        end else begin
            core_mode  = in_mode;
            core_stype = stype_e'(bus.in_stype);
            core_amt   = src_amt;
            core_flags = src_flags;
            core_rm    = src_rm;
            core_c     = bus.in_c;
        end
    end

    shifter_core #(.DATA_W(DATA_W)) u_core (
        .mode      (core_mode),
        .stype     (core_stype),
        .amt       (core_amt),
        .flags     (core_flags),
        .rm        (core_rm),
        .c         (core_c),
        .operand_c (core_op),
        .carry_c   (core_cy)
    );

    always_comb begin
        state_n  = state;
        capture  = 1'b0;
        load_out = 1'b0;
        valid_n  = valid_q;
        ready    = !flush && ((state == ST_IDLE) || (state == ST_DONE && bus.out_ready));
        accept   = bus.in_valid && ready;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (in_mode == MODE_REG_SHIFT) begin
                        state_n = ST_EXEC;
                        capture = 1'b1;
                        valid_n = 1'b0;
                    end else begin
                        state_n  = ST_DONE;
                        load_out = 1'b1;
                        valid_n  = 1'b1;
                    end
                end else if (state == ST_DONE && bus.out_ready) begin
                    state_n = ST_IDLE;
                    valid_n = 1'b0;
                end
            end
            ST_EXEC: begin
                state_n  = ST_DONE;
                load_out = 1'b1;
                valid_n  = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
        if (flush) begin
            state_n  = ST_IDLE;
            capture  = 1'b0;
            load_out = 1'b0;
            valid_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_stype <= STYPE_LSL;
            h_amt   <= '0;
            h_flags <= '0;
            h_rm    <= '0;
            h_c     <= 1'b0;
        end else if (capture) begin
            h_stype <= stype_e'(bus.in_stype);
            h_amt   <= src_amt;
            h_flags <= src_flags;
            h_rm    <= src_rm;
            h_c     <= bus.in_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            operand_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            valid_q <= valid_n;
            if (load_out) begin
                operand_q <= core_op;
                carry_q   <= core_cy;
            end
        end
    end

    assign bus.in_ready    = ready;
    assign bus.out_valid   = valid_q;
    assign bus.out_operand = operand_q;
    assign bus.out_carry   = carry_q;
endmodule

// File: tb/tb_shifter_operand_pipe.sv
// Directed bench for shifter_operand_pipe: vector table at DATA_W=32 plus handshake, flush, reset and DATA_W=16 sequences.
module tb_shifter_operand_pipe;

    localparam logic [1:0] M_ROT = 2'd0, M_SH = 2'd1, M_REG = 2'd2, M_PASS = 2'd3;
    localparam logic [1:0] S_LSL = 2'd0, S_LSR = 2'd1, S_ASR = 2'd2, S_ROR = 2'd3;

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  stype;
        logic [7:0]  imm8;
        logic [3:0]  rot;
        logic [4:0]  amt;
        logic [7:0]  rs;
        logic [31:0] rm;
        logic        c;
        logic [31:0] op;
        logic        cy;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush32 = 1'b0;
    logic flush16 = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[22];
    vec_t v;

    always #5 clk = ~clk;

    shifter_operand_pipe_if #(.DATA_W(32)) b32 ();
    shifter_operand_pipe_if #(.DATA_W(16)) b16 ();

    shifter_operand_pipe #(.DATA_W(32)) u32 (.clk(clk), .rst_n(rst_n), .flush(flush32), .bus(b32.slave));
    shifter_operand_pipe #(.DATA_W(16)) u16 (.clk(clk), .rst_n(rst_n), .flush(flush16), .bus(b16.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send32(input vec_t t);
        @(negedge clk);
        b32.in_mode = t.mode; b32.in_stype = t.stype; b32.in_imm8 = t.imm8; b32.in_rot = t.rot;
        b32.in_amt = t.amt; b32.in_rs = t.rs; b32.in_rm = t.rm; b32.in_c = t.c;
        b32.in_valid = 1'b1;
        for (int g = 0; g < 20 && !b32.in_ready; g++) @(negedge clk);
        if (!b32.in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1 b32.in_valid = 1'b0;
    endtask

    task automatic get32(input string tag, input vec_t t);
        int n = 0;
        do begin @(negedge clk); n++; end while (!b32.out_valid && n < 8);
        check({tag, "_lat"}, 64'(n), 64'(t.lat));
        check({tag, "_valid"}, b32.out_valid, 1);
        check({tag, "_op"}, b32.out_operand, t.op);
        check({tag, "_cy"}, b32.out_carry, t.cy);
    endtask

    task automatic run16(input string tag, input logic [1:0] mode, input logic [1:0] stype,
                         input logic [7:0] imm8, input logic [2:0] rot, input logic [3:0] amt,
                         input logic [7:0] rs, input logic [15:0] rm, input logic c,
                         input logic [15:0] op, input logic cy, input int lat);
        int n = 0;
        @(negedge clk);
        b16.in_mode = mode; b16.in_stype = stype; b16.in_imm8 = imm8; b16.in_rot = rot;
        b16.in_amt = amt; b16.in_rs = rs; b16.in_rm = rm; b16.in_c = c;
        b16.in_valid = 1'b1;
        for (int g = 0; g < 20 && !b16.in_ready; g++) @(negedge clk);
        if (!b16.in_ready) check({tag, "_accept_timeout"}, 0, 1);
        @(posedge clk);
        #1 b16.in_valid = 1'b0;
        do begin @(negedge clk); n++; end while (!b16.out_valid && n < 8);
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_op"}, b16.out_operand, op);
        check({tag, "_cy"}, b16.out_carry, cy);
    endtask

    initial begin
        rst_n = 1'b0;
        b32.in_valid = 0; b32.in_mode = 0; b32.in_stype = 0; b32.in_imm8 = 0; b32.in_rot = 0;
        b32.in_amt = 0; b32.in_rs = 0; b32.in_rm = 0; b32.in_c = 0; b32.out_ready = 1;
        b16.in_valid = 0; b16.in_mode = 0; b16.in_stype = 0; b16.in_imm8 = 0; b16.in_rot = 0;
        b16.in_amt = 0; b16.in_rs = 0; b16.in_rm = 0; b16.in_c = 0; b16.out_ready = 1;

        #12;
        check("rst_in_ready", b32.in_ready, 1);
        check("rst_out_valid", b32.out_valid, 0);
        check("rst_operand", b32.out_operand, 0);
        check("rst_carry", b32.out_carry, 0);
        check("rst16_in_ready", b16.in_ready, 1);
        check("rst16_out_valid", b16.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        //            mode    stype  imm8   rot   amt   rs      rm            c     op            cy    lat
        vecs[0]  = '{M_ROT,  S_LSL, 8'hFF, 4'd4, 5'd0, 8'd0,   32'h0,        1'b0, 32'hFF000000, 1'b1, 1};
        vecs[1]  = '{M_ROT,  S_LSL, 8'hFF, 4'd0, 5'd0, 8'd0,   32'h0,        1'b1, 32'h000000FF, 1'b1, 1};
        vecs[2]  = '{M_ROT,  S_LSL, 8'h81, 4'd1, 5'd0, 8'd0,   32'h0,        1'b1, 32'h40000020, 1'b0, 1};
        vecs[3]  = '{M_SH,   S_LSR, 8'h00, 4'd0, 5'd0, 8'd0,   32'h80000000, 1'b0, 32'h00000000, 1'b1, 1};
        vecs[4]  = '{M_SH,   S_ASR, 8'h00, 4'd0, 5'd0, 8'd0,   32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1, 1};
        vecs[5]  = '{M_SH,   S_ROR, 8'h00, 4'd0, 5'd0, 8'd0,   32'h00000001, 1'b1, 32'h80000000, 1'b1, 1};
        vecs[6]  = '{M_SH,   S_LSL, 8'h00, 4'd0, 5'd0, 8'd0,   32'h12345678, 1'b1, 32'h12345678, 1'b1, 1};
        vecs[7]  = '{M_SH,   S_LSL, 8'h00, 4'd0, 5'd4, 8'd0,   32'hF0000001, 1'b0, 32'h00000010, 1'b1, 1};
        vecs[8]  = '{M_SH,   S_LSR, 8'h00, 4'd0, 5'd1, 8'd0,   32'h00000003, 1'b0, 32'h00000001, 1'b1, 1};
        vecs[9]  = '{M_SH,   S_ASR, 8'h00, 4'd0, 5'd4, 8'd0,   32'h80000010, 1'b1, 32'hF8000001, 1'b0, 1};
        vecs[10] = '{M_SH,   S_ROR, 8'h00, 4'd0, 5'd8, 8'd0,   32'h12345678, 1'b1, 32'h78123456, 1'b0, 1};
        vecs[11] = '{M_REG,  S_LSL, 8'h00, 4'd0, 5'd0, 8'd32,  32'h00000001, 1'b0, 32'h00000000, 1'b1, 2};
        vecs[12] = '{M_REG,  S_LSL, 8'h00, 4'd0, 5'd0, 8'd33,  32'h00000001, 1'b1, 32'h00000000, 1'b0, 2};
        vecs[13] = '{M_REG,  S_ROR, 8'h00, 4'd0, 5'd0, 8'd32,  32'h80000001, 1'b0, 32'h80000001, 1'b1, 2};
        vecs[14] = '{M_REG,  S_LSL, 8'h00, 4'd0, 5'd0, 8'd0,   32'h00000005, 1'b1, 32'h00000005, 1'b1, 2};
        vecs[15] = '{M_REG,  S_LSR, 8'h00, 4'd0, 5'd0, 8'd32,  32'h80000000, 1'b0, 32'h00000000, 1'b1, 2};
        vecs[16] = '{M_REG,  S_ASR, 8'h00, 4'd0, 5'd0, 8'd200, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1, 2};
        vecs[17] = '{M_REG,  S_ASR, 8'h00, 4'd0, 5'd0, 8'd200, 32'h7FFFFFFF, 1'b1, 32'h00000000, 1'b0, 2};
        vecs[18] = '{M_REG,  S_ROR, 8'h00, 4'd0, 5'd0, 8'd36,  32'h0000000F, 1'b0, 32'hF0000000, 1'b1, 2};
        vecs[19] = '{M_REG,  S_LSR, 8'h00, 4'd0, 5'd0, 8'd4,   32'h0000001F, 1'b0, 32'h00000001, 1'b1, 2};
        vecs[20] = '{M_PASS, S_LSL, 8'h00, 4'd0, 5'd0, 8'd0,   32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 1};
        vecs[21] = '{M_REG,  S_ROR, 8'h00, 4'd0, 5'd0, 8'd0,   32'h80000003, 1'b0, 32'h80000003, 1'b0, 2};

        for (int i = 0; i < 22; i++) begin
            send32(vecs[i]);
            get32($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: result held for 5 cycles while a second request waits
        @(negedge clk);
        b32.out_ready = 1'b0;
        v = '{M_SH, S_LSL, 8'h00, 4'd0, 5'd1, 8'd0, 32'h1, 1'b0, 32'h2, 1'b0, 1};
        send32(v);
        b32.in_amt = 5'd2;
        b32.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d_valid", k), b32.out_valid, 1);
            check($sformatf("hold%0d_op", k), b32.out_operand, 32'h2);
            check($sformatf("hold%0d_cy", k), b32.out_carry, 0);
            check($sformatf("hold%0d_in_ready", k), b32.in_ready, 0);
        end
        b32.out_ready = 1'b1;
        @(posedge clk);
        #1 b32.in_valid = 1'b0;
        @(negedge clk);
        check("release_valid", b32.out_valid, 1);
        check("release_op", b32.out_operand, 32'h4);
        @(negedge clk);
        check("release_drain", b32.out_valid, 0);

        // Four back-to-back immediate shifts, one result per cycle
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check($sformatf("b2b%0d_valid", k - 1), b32.out_valid, 1);
                check($sformatf("b2b%0d_op", k - 1), b32.out_operand, 64'(32'h1 << k));
            end
            check($sformatf("b2b%0d_in_ready", k), b32.in_ready, 1);
            b32.in_mode = M_SH; b32.in_stype = S_LSL; b32.in_amt = 5'(k + 1);
            b32.in_rm = 32'h1; b32.in_valid = 1'b1;
        end
        @(negedge clk);
        b32.in_valid = 1'b0;
        check("b2b3_valid", b32.out_valid, 1);
        check("b2b3_op", b32.out_operand, 32'h10);
        @(negedge clk);
        check("b2b_drain", b32.out_valid, 0);

        // Flush while in EXEC
        v = '{M_REG, S_LSL, 8'h00, 4'd0, 5'd0, 8'd4, 32'h1, 1'b0, 32'h10, 1'b0, 2};
        send32(v);
        @(negedge clk);
        flush32 = 1'b1;
        #1 check("flush_exec_in_ready", b32.in_ready, 0);
        @(negedge clk);
        flush32 = 1'b0;
        check("flush_exec_valid", b32.out_valid, 0);
        @(negedge clk);
        check("flush_exec_valid2", b32.out_valid, 0);

        // Flush while in DONE with a competing request on the input
        b32.out_ready = 1'b0;
        v = '{M_SH, S_LSL, 8'h00, 4'd0, 5'd3, 8'd0, 32'h1, 1'b0, 32'h8, 1'b0, 1};
        send32(v);
        @(negedge clk);
        check("flush_done_pre_valid", b32.out_valid, 1);
        flush32 = 1'b1;
        b32.out_ready = 1'b1;
        b32.in_amt = 5'd5;
        b32.in_valid = 1'b1;
        #1 check("flush_done_in_ready", b32.in_ready, 0);
        @(negedge clk);
        flush32 = 1'b0;
        b32.in_valid = 1'b0;
        check("flush_done_valid", b32.out_valid, 0);
        @(negedge clk);
        check("flush_done_valid2", b32.out_valid, 0);

        send32(vecs[20]);
        get32("post_flush", vecs[20]);

        // Asynchronous reset while a register shift sits in EXEC
        v = '{M_REG, S_LSL, 8'h00, 4'd0, 5'd0, 8'd1, 32'h3, 1'b0, 32'h6, 1'b0, 2};
        send32(v);
        @(negedge clk);
        check("exec_in_ready", b32.in_ready, 0);
        check("exec_pre_op", b32.out_operand, 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", b32.out_valid, 0);
        check("arst_op", b32.out_operand, 0);
        check("arst_cy", b32.out_carry, 0);
        check("arst_in_ready", b32.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_lost", b32.out_valid, 0);
        send32(vecs[11]);
        get32("post_rst", vecs[11]);

        // DATA_W = 16 instance
        run16("w16_lsl16",  M_REG, S_LSL, 8'h00, 3'd0, 4'd0, 8'd16, 16'h0001, 1'b0, 16'h0000, 1'b1, 2);
        run16("w16_rot",    M_ROT, S_LSL, 8'h81, 3'd1, 4'd0, 8'd0,  16'h0000, 1'b1, 16'h4020, 1'b0, 1);
        run16("w16_lsl17",  M_REG, S_LSL, 8'h00, 3'd0, 4'd0, 8'd17, 16'h0001, 1'b1, 16'h0000, 1'b0, 2);
        run16("w16_asr0",   M_SH,  S_ASR, 8'h00, 3'd0, 4'd0, 8'd0,  16'h8000, 1'b0, 16'hFFFF, 1'b1, 1);
        run16("w16_ror20",  M_REG, S_ROR, 8'h00, 3'd0, 4'd0, 8'd20, 16'h000F, 1'b0, 16'hF000, 1'b1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
